// File: rtl/array_shift_down_pkg.sv
// Shared types and constants for the heap array shift-down engine.
package zero_pkg;
    localparam int MemoryElementWidth = 12;
    localparam int NArea = 4;
    localparam int NArrays = 2;
    localparam int HeapDepth = NArea * NArrays;

    typedef logic [MemoryElementWidth-1:0] mem_word_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FETCH,
        CAPTURE,
        READ,
        WRITE,
        CLEAR,
        FINISH
    } shift_state_t;
endpackage

// File: rtl/array_shift_down.sv
// Removes heap[base+pos], slides the tail of the array down one slot and shrinks its length.
// Define ARRAY_SHIFT_DOWN_CLEAR_EN to zero the vacated last slot before finishing.
module array_shift_down
    import zero_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    output logic                          ready,
    input  logic [MemoryElementWidth-1:0] array_in,
    input  logic [MemoryElementWidth-1:0] pos_in,
    input  logic [MemoryElementWidth-1:0] len_in,
    output logic [MemoryElementWidth-1:0] mem_addr,
    output logic                          mem_re,
    input  logic [MemoryElementWidth-1:0] mem_rdata,
    output logic                          mem_we,
    output logic [MemoryElementWidth-1:0] mem_wdata,
    output logic                          len_we,
    output logic [MemoryElementWidth-1:0] len_out,
    output logic                          done,
    output logic                          error,
    output logic [MemoryElementWidth-1:0] removed
);

    localparam mem_word_t One = mem_word_t'(1);
    localparam mem_word_t Two = mem_word_t'(2);
    localparam mem_word_t AreaSize = mem_word_t'(NArea);

`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
    localparam shift_state_t TailState = CLEAR;
`else
    localparam shift_state_t TailState = FINISH;
`endif

    shift_state_t state;
    mem_word_t    base_r;
    mem_word_t    pos_r;
    mem_word_t    len_r;
    mem_word_t    idx;
    logic         err_r;

    assign ready = (state == IDLE);

    // Sequencer: the completion flags are registered and pulse in the cycle after FINISH.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            base_r  <= '0;
            pos_r   <= '0;
            len_r   <= '0;
            idx     <= '0;
            err_r   <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            len_we  <= 1'b0;
            len_out <= '0;
            removed <= '0;
        end else begin
            done   <= 1'b0;
            error  <= 1'b0;
            len_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r <= array_in * AreaSize;
                        pos_r  <= pos_in;
                        len_r  <= len_in;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (pos_r >= len_r || len_r > AreaSize) begin
                        err_r <= 1'b1;
                        state <= FINISH;
                    end else begin
                        err_r <= 1'b0;
                        state <= FETCH;
                    end
                end
                FETCH: state <= CAPTURE;
                CAPTURE: begin
                    removed <= mem_rdata;
                    idx     <= pos_r;
                    state   <= (pos_r + One < len_r) ? READ : TailState;
                end
                READ: state <= WRITE;
                WRITE: begin
                    idx   <= idx + One;
                    state <= (idx + Two < len_r) ? READ : TailState;
                end
                CLEAR: state <= FINISH;
                FINISH: begin
                    done   <= 1'b1;
                    error  <= err_r;
                    len_we <= ~err_r;
                    if (!err_r) len_out <= len_r - One;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Heap port is decoded from the state so read data lands in the following state.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            FETCH: begin
                mem_re   = 1'b1;
                mem_addr = base_r + pos_r;
            end
            READ: begin
                mem_re   = 1'b1;
                mem_addr = base_r + idx + One;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = base_r + idx;
                mem_wdata = mem_rdata;
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = base_r + len_r - One;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_array_shift_down.sv
// Directed bench for array_shift_down with a behavioural heap model.
module tb_array_shift_down;
    import zero_pkg::*;

    localparam int AW = $clog2(HeapDepth);
`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
    localparam int ClearAdd = 1;
`else
    localparam int ClearAdd = 0;
`endif

    logic      clock = 1'b0;
    logic      reset = 1'b1;
    logic      start = 1'b0;
    logic      ready;
    mem_word_t array_in = '0;
    mem_word_t pos_in = '0;
    mem_word_t len_in = '0;
    mem_word_t mem_addr;
    logic      mem_re;
    mem_word_t mem_rdata = '0;
    logic      mem_we;
    mem_word_t mem_wdata;
    logic      len_we;
    mem_word_t len_out;
    logic      done;
    logic      error;
    mem_word_t removed;

    mem_word_t        heap [HeapDepth];
    logic             load_en = 1'b0;
    logic [AW-1:0]    load_addr = '0;
    mem_word_t        load_data = '0;

    int total = 0;
    int bad = 0;

    int op_cycles, op_re, op_we, op_both, op_lenwe, op_err, op_len_out;
    bit op_done;

    array_shift_down dut (
        .clock(clock), .reset(reset), .start(start), .ready(ready),
        .array_in(array_in), .pos_in(pos_in), .len_in(len_in),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .len_we(len_we), .len_out(len_out),
        .done(done), .error(error), .removed(removed)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (load_en) heap[load_addr] <= load_data;
        else if (mem_we && mem_addr < mem_word_t'(HeapDepth)) heap[mem_addr[AW-1:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= (mem_addr < mem_word_t'(HeapDepth)) ? heap[mem_addr[AW-1:0]] : '0;
    end

    task automatic check_output(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic load_array(input int arr, input int v0, input int v1, input int v2, input int v3);
        int vals [4];
        vals = '{v0, v1, v2, v3};
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            load_en = 1'b1;
            load_addr = AW'(arr * NArea + k);
            load_data = mem_word_t'(vals[k]);
        end
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic check_heap(input string tag, input int arr, input int v0, input int v1, input int v2, input int v3);
        int vals [4];
        vals = '{v0, v1, v2, v3};
        for (int k = 0; k < 4; k++)
            check_output($sformatf("%s[%0d]", tag, k), int'(heap[arr * NArea + k]), vals[k]);
    endtask

    // Issues one request and watches the port until done; hold_start keeps start high throughout.
    task automatic apply_stimulus(input int arr, input int pos, input int len, input bit hold_start);
        @(negedge clock);
        array_in = mem_word_t'(arr);
        pos_in = mem_word_t'(pos);
        len_in = mem_word_t'(len);
        start = 1'b1;
        @(posedge clock);
        #1;
        op_cycles = 0; op_re = 0; op_we = 0; op_both = 0; op_lenwe = 0;
        op_err = 0; op_len_out = 0; op_done = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (!hold_start) start = 1'b0;
            @(posedge clock);
            #1;
            op_cycles = k;
            if (mem_re) op_re++;
            if (mem_we) op_we++;
            if (mem_re && mem_we) op_both++;
            if (len_we) op_lenwe++;
            if (done) begin
                op_done = 1'b1;
                op_err = int'(error);
                op_len_out = int'(len_out);
                break;
            end
        end
        @(negedge clock);
        start = 1'b0;
        check_output("done_seen", int'(op_done), 1);
    endtask

    initial begin
        int quiet;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_output("rst_ready", int'(ready), 1);
        check_output("rst_done", int'(done), 0);
        check_output("rst_error", int'(error), 0);
        check_output("rst_strobes", int'({mem_re, mem_we, len_we}), 0);
        check_output("rst_removed", int'(removed), 0);
        check_output("rst_addr", int'(mem_addr), 0);
        check_output("rst_len_out", int'(len_out), 0);

        // Full-length removal from the head of array 1.
        load_array(1, 99, 0, 1, 2);
        apply_stimulus(1, 0, 4, 1'b0);
        check_output("head_cycles", op_cycles, 10 + ClearAdd);
        check_output("head_removed", int'(removed), 99);
        check_output("head_error", op_err, 0);
        check_output("head_len_out", op_len_out, 3);
        check_output("head_lenwe", op_lenwe, 1);
        check_output("head_reads", op_re, 4);
        check_output("head_writes", op_we, 3 + ClearAdd);
        check_output("head_overlap", op_both, 0);
        check_heap("head_heap", 1, 0, 1, 2, ClearAdd ? 0 : 2);

        // Removing the last element moves nothing.
        load_array(1, 5, 6, 7, 55);
        apply_stimulus(1, 2, 3, 1'b0);
        check_output("last_cycles", op_cycles, 4 + ClearAdd);
        check_output("last_removed", int'(removed), 7);
        check_output("last_writes", op_we, ClearAdd);
        check_output("last_reads", op_re, 1);
        check_output("last_len_out", op_len_out, 2);
        check_heap("last_heap", 1, 5, 6, ClearAdd ? 0 : 7, 55);

        // Error paths leave memory, length and removed untouched.
        apply_stimulus(1, 3, 3, 1'b0);
        check_output("pos_eq_len_cycles", op_cycles, 2);
        check_output("pos_eq_len_error", op_err, 1);
        check_output("pos_eq_len_strobes", op_re + op_we + op_lenwe, 0);
        check_output("pos_eq_len_removed", int'(removed), 7);
        apply_stimulus(0, 0, 0, 1'b0);
        check_output("len0_error", op_err, 1);
        check_output("len0_cycles", op_cycles, 2);
        apply_stimulus(0, 0, 5, 1'b0);
        check_output("len5_error", op_err, 1);
        check_output("len5_strobes", op_re + op_we + op_lenwe, 0);

        // Reset while the first move is being written.
        load_array(1, 9, 8, 7, 6);
        @(negedge clock);
        array_in = 12'd1; pos_in = 12'd0; len_in = 12'd4; start = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check_output("abort_in_write", int'(mem_we), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_output("abort_ready", int'(ready), 1);
        check_output("abort_done", int'(done), 0);
        check_output("abort_removed", int'(removed), 0);
        @(negedge clock);
        reset = 1'b0;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            #1;
            quiet += int'(done) + int'(len_we) + int'(mem_re) + int'(mem_we);
        end
        check_output("abort_quiet", quiet, 0);
        check_heap("abort_heap", 1, 8, 8, 7, 6);

        // start held high through busy and FINISH cycles must not retrigger.
        load_array(1, 10, 20, 30, 40);
        load_array(0, 1, 2, 3, 4);
        apply_stimulus(1, 1, 4, 1'b1);
        check_output("hold_cycles", op_cycles, 8 + ClearAdd);
        check_output("hold_removed", int'(removed), 20);
        check_output("hold_len_out", op_len_out, 3);
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            quiet += int'(!ready) + int'(mem_re) + int'(done);
        end
        check_output("hold_no_retrigger", quiet, 0);
        check_heap("hold_heap", 1, 10, 30, 40, ClearAdd ? 0 : 40);

        apply_stimulus(0, 0, 2, 1'b0);
        check_output("arr0_cycles", op_cycles, 6 + ClearAdd);
        check_output("arr0_removed", int'(removed), 1);
        check_output("arr0_len_out", op_len_out, 1);
        check_heap("arr0_heap", 0, 2, ClearAdd ? 0 : 2, 3, 4);
        check_heap("arr1_untouched", 1, 10, 30, 40, ClearAdd ? 0 : 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
